// File: rtl/psum_pad_ctrl_pkg.sv
// Shared constants for the partial-sum pad controller: parameter defaults,
// accumulate_mode encodings and drain FSM state encodings.
package psum_pad_ctrl_pkg;

    localparam int DATA_WIDTH_DEF      = 16;
    localparam int OUT_DATA_WIDTH_DEF  = 36;
    localparam int OFPAD_WIDTH_DEF     = 4;
    localparam int MAX_SHIFT_WIDTH_DEF = 4;
    localparam int PSUM_AW_DEF         = 4;
    localparam int PSUM_DEPTH_DEF      = 16;

    localparam logic [1:0] ACC_MODE = 2'b10;
    localparam logic [1:0] MAC_MODE = 2'b01;

    typedef enum logic [1:0] {
        DRN_IDLE  = 2'd0,
        DRN_DRAIN = 2'd1,
        DRN_DONE  = 2'd2
    } drain_state_e;

endpackage

// File: rtl/psum_sat.sv
// Signed saturation of a wide accumulator value to a narrow signed word.
// Purely combinational.
module psum_sat
    import psum_pad_ctrl_pkg::*;
#(
    parameter int IN_W  = OUT_DATA_WIDTH_DEF,
    parameter int OUT_W = DATA_WIDTH_DEF
) (
    input  logic signed [IN_W-1:0]  din_i,
    output logic        [OUT_W-1:0] dout_o
);

    // The value fits iff every bit from the output sign bit upwards agrees.
    logic [IN_W-OUT_W:0] top_bits;
    assign top_bits = din_i[IN_W-1:OUT_W-1];

    always_comb begin
        dout_o = din_i[OUT_W-1:0];
        if (!((&top_bits) || !(|top_bits))) begin
            if (din_i[IN_W-1]) dout_o = {1'b1, {(OUT_W-1){1'b0}}};
            else               dout_o = {1'b0, {(OUT_W-1){1'b1}}};
        end
    end

endmodule

// File: rtl/psum_pad_ctrl.sv
// Partial-sum scratch pad: addressed writes of saturated MAC results, adder
// operand mux, and a valid/ready drain port (pad writes stall the drain).
module psum_pad_ctrl
    import psum_pad_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
    parameter int OUT_DATA_WIDTH  = OUT_DATA_WIDTH_DEF,
    parameter int OFPAD_WIDTH     = OFPAD_WIDTH_DEF,
    parameter int MAX_SHIFT_WIDTH = MAX_SHIFT_WIDTH_DEF,
    parameter int PSUM_AW         = PSUM_AW_DEF,
    parameter int PSUM_DEPTH      = PSUM_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             mode,
    input  logic [1:0]                       accumulate_mode,
    input  logic                             psum_initial_flag,
    input  logic                             psum_store_flag,
    input  logic                             mac_finish_flag,
    input  logic [OFPAD_WIDTH-1:0]           cnt_b,
    input  logic [MAX_SHIFT_WIDTH-1:0]       cnt_shift,
    input  logic [OFPAD_WIDTH-1:0]           para_filter_num,
    input  logic signed [OUT_DATA_WIDTH-1:0] accum_out,
    input  logic [DATA_WIDTH-1:0]            input_psum,
    output logic [DATA_WIDTH-1:0]            internal_psum,
    output logic [DATA_WIDTH-1:0]            external_psum,
    input  logic                             drain_start,
    input  logic [PSUM_AW:0]                 drain_num,
    output logic [DATA_WIDTH-1:0]            psum_out,
    output logic                             psum_out_valid,
    input  logic                             psum_out_ready,
    output logic                             drain_busy,
    output logic                             drain_done,
    output logic                             addr_err
);

    // Addresses are kept wide so out-of-range shift offsets are caught, not aliased.
    localparam int CW = PSUM_AW + 4;

    logic [CW-1:0]         c_d, c_q, c_delay_q, wr_addr_full;
    logic [DATA_WIDTH-1:0] pad_q [PSUM_DEPTH];
    logic [DATA_WIDTH-1:0] sat_dat, pad_at_c;
    logic                  wr_req, wr_in_range, wr_en, addr_err_q;
    logic [PSUM_AW-1:0]    rptr_d, rptr_q;
    logic [PSUM_AW:0]      cnt_d, cnt_q;
    logic                  beat;
    drain_state_e          state_d, state_q;

    psum_sat #(.IN_W(OUT_DATA_WIDTH), .OUT_W(DATA_WIDTH)) u_sat (
        .din_i  (accum_out),
        .dout_o (sat_dat)
    );

    always_comb begin
        c_d = CW'(cnt_b);
        if (mode) c_d = CW'(cnt_b) + CW'(cnt_shift) * CW'(para_filter_num);
    end

    assign wr_req       = mode ? (mac_finish_flag | psum_store_flag) : psum_store_flag;
    assign wr_addr_full = mode ? c_q : c_delay_q;
    assign wr_in_range  = wr_addr_full < CW'(PSUM_DEPTH);
    assign wr_en        = wr_req & wr_in_range;
    assign pad_at_c     = (c_q < CW'(PSUM_DEPTH)) ? pad_q[c_q[PSUM_AW-1:0]] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c_q        <= '0;
            c_delay_q  <= '0;
            addr_err_q <= 1'b0;
            for (int i = 0; i < PSUM_DEPTH; i++) pad_q[i] <= '0;
        end else begin
            c_q        <= c_d;
            c_delay_q  <= c_q;
            addr_err_q <= addr_err_q | (wr_req & ~wr_in_range);
            if (wr_en) pad_q[wr_addr_full[PSUM_AW-1:0]] <= sat_dat;
        end
    end

    assign addr_err = addr_err_q;

    always_comb begin
        internal_psum = '0;
        external_psum = '0;
        case (accumulate_mode)
            ACC_MODE: begin
                internal_psum = pad_at_c;
                external_psum = input_psum;
            end
            MAC_MODE: internal_psum = psum_initial_flag ? pad_at_c : accum_out[DATA_WIDTH-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= DRN_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            DRN_IDLE:  if (drain_start) state_d = (drain_num != '0) ? DRN_DRAIN : DRN_DONE;
            DRN_DRAIN: if (beat && cnt_q == (PSUM_AW+1)'(1)) state_d = DRN_DONE;
            DRN_DONE:  state_d = DRN_IDLE;
            default:   state_d = DRN_IDLE;
        endcase
    end

    always_comb begin
        psum_out_valid = (state_q == DRN_DRAIN) & ~wr_en;
        psum_out       = (state_q == DRN_DRAIN) ? pad_q[rptr_q] : '0;
        drain_busy     = (state_q != DRN_IDLE);
        drain_done     = (state_q == DRN_DONE);
    end

    assign beat = psum_out_valid & psum_out_ready;

    always_comb begin
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (state_q == DRN_IDLE && drain_start && drain_num != '0) begin
            rptr_d = '0;
            cnt_d  = drain_num;
        end else if (beat) begin
            rptr_d = rptr_q + 1'b1;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: tb/tb_psum_pad_ctrl.sv
// Directed bench for psum_pad_ctrl: addressing, saturation, operand mux,
// drain handshake and reset behaviour.
module tb_psum_pad_ctrl;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               mode;
    logic [1:0]         accumulate_mode;
    logic               psum_initial_flag, psum_store_flag, mac_finish_flag;
    logic [3:0]         cnt_b, cnt_shift, para_filter_num;
    logic signed [35:0] accum_out;
    logic [15:0]        input_psum, internal_psum, external_psum, psum_out;
    logic               drain_start;
    logic [4:0]         drain_num;
    logic               psum_out_valid, psum_out_ready, drain_busy, drain_done, addr_err;

    int checks = 0;
    int errors = 0;

    psum_pad_ctrl dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .accumulate_mode(accumulate_mode),
        .psum_initial_flag(psum_initial_flag), .psum_store_flag(psum_store_flag),
        .mac_finish_flag(mac_finish_flag), .cnt_b(cnt_b), .cnt_shift(cnt_shift),
        .para_filter_num(para_filter_num), .accum_out(accum_out), .input_psum(input_psum),
        .internal_psum(internal_psum), .external_psum(external_psum),
        .drain_start(drain_start), .drain_num(drain_num), .psum_out(psum_out),
        .psum_out_valid(psum_out_valid), .psum_out_ready(psum_out_ready),
        .drain_busy(drain_busy), .drain_done(drain_done), .addr_err(addr_err)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mode = 1'b0; accumulate_mode = 2'b00;
        psum_initial_flag = 1'b0; psum_store_flag = 1'b0; mac_finish_flag = 1'b0;
        cnt_b = '0; cnt_shift = '0; para_filter_num = '0;
        accum_out = '0; input_psum = '0;
        drain_start = 1'b0; drain_num = '0; psum_out_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
    endtask

    task automatic write_pad(input logic [3:0] a, input logic signed [35:0] v);
        mode = 1'b1; cnt_b = a; cnt_shift = '0; para_filter_num = '0; accumulate_mode = 2'b00;
        tick();
        accum_out = v; mac_finish_flag = 1'b1;
        tick();
        mac_finish_flag = 1'b0;
    endtask

    task automatic read_pad(input logic [3:0] a, output logic [15:0] d);
        mode = 1'b1; cnt_b = a; cnt_shift = '0; para_filter_num = '0; accumulate_mode = 2'b10;
        tick();
        d = internal_psum;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 1'b0;
        accumulate_mode = 2'b10; input_psum = 16'h0007;
        #2;
        checks++; if (psum_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h want 0", psum_out_valid); end
        checks++; if (drain_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0h want 0", drain_busy); end
        checks++; if (drain_done !== 1'b0) begin errors++; $display("FAIL reset_done got %0h want 0", drain_done); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL reset_addr_err got %0h want 0", addr_err); end
        checks++; if (internal_psum !== 16'h0000) begin errors++; $display("FAIL reset_internal got %0h want 0", internal_psum); end
        checks++; if (external_psum !== 16'h0007) begin errors++; $display("FAIL reset_external got %0h want 7", external_psum); end
        tick(); tick();
        rst_n = 1'b1;
        idle_inputs();
    endtask

    task automatic test_mode0_store();
        logic [15:0] d;
        mode = 1'b0; cnt_b = 4'd2; accum_out = 36'sd100;
        tick();
        cnt_b = 4'd5;
        tick();
        psum_store_flag = 1'b1;
        tick();
        psum_store_flag = 1'b0;
        mode = 1'b0; cnt_b = 4'd2; accumulate_mode = 2'b10;
        tick();
        checks++; if (internal_psum !== 16'd100) begin errors++; $display("FAIL mode0_pad2 got %0d want 100", internal_psum); end
        read_pad(4'd5, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL mode0_pad5_untouched got %0d want 0", d); end
    endtask

    task automatic test_mode1_addr();
        logic [15:0] d;
        mode = 1'b1; cnt_b = 4'd1; cnt_shift = 4'd2; para_filter_num = 4'd3; accumulate_mode = 2'b00;
        tick();
        mac_finish_flag = 1'b1; accum_out = 36'sd777;
        tick();
        mac_finish_flag = 1'b0; accumulate_mode = 2'b10;
        #1;
        checks++; if (internal_psum !== 16'd777) begin errors++; $display("FAIL mode1_pad7 got %0d want 777", internal_psum); end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL mode1_no_err got %0h want 0", addr_err); end
        accumulate_mode = 2'b00; cnt_shift = 4'd5;
        tick();
        mac_finish_flag = 1'b1; accum_out = 36'sd555;
        tick();
        mac_finish_flag = 1'b0;
        #1;
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL mode1_oob_err got %0h want 1", addr_err); end
        read_pad(4'd0, d);
        checks++; if (d !== 16'd0) begin errors++; $display("FAIL mode1_no_alias got %0d want 0", d); end
        cnt_b = 4'd8; accumulate_mode = 2'b00;
        tick();
        psum_store_flag = 1'b1; accum_out = -36'sd5;
        tick();
        psum_store_flag = 1'b0;
        read_pad(4'd8, d);
        checks++; if (d !== 16'hFFFB) begin errors++; $display("FAIL mode1_store_flag got %0h want fffb", d); end
        read_pad(4'd7, d);
        checks++; if (d !== 16'd777) begin errors++; $display("FAIL mode1_pad7_kept got %0d want 777", d); end
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL addr_err_sticky got %0h want 1", addr_err); end
    endtask

    task automatic test_saturation();
        logic signed [35:0] vals [6] = '{36'sd40000, -36'sd40000, 36'sd32767, -36'sd32768, 36'sd32768, -36'sd32769};
        logic [15:0]        exps [6] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h8000};
        logic [15:0]        d;
        for (int i = 0; i < 6; i++) write_pad(4'(9 + i), vals[i]);
        for (int i = 0; i < 6; i++) begin
            read_pad(4'(9 + i), d);
            checks++; if (d !== exps[i]) begin errors++; $display("FAIL sat_%0d got %0h want %0h", i, d, exps[i]); end
        end
    endtask

    task automatic test_operand_mux();
        do_reset();
        write_pad(4'd0, 36'sd5);
        cnt_b = 4'd0;
        tick();
        accumulate_mode = 2'b10; input_psum = 16'd3;
        #1;
        checks++; if (internal_psum !== 16'd5) begin errors++; $display("FAIL mux_acc_int got %0d want 5", internal_psum); end
        checks++; if (external_psum !== 16'd3) begin errors++; $display("FAIL mux_acc_ext got %0d want 3", external_psum); end
        accumulate_mode = 2'b01; psum_initial_flag = 1'b1;
        #1;
        checks++; if (internal_psum !== 16'd5) begin errors++; $display("FAIL mux_mac_init_int got %0d want 5", internal_psum); end
        checks++; if (external_psum !== 16'd0) begin errors++; $display("FAIL mux_mac_init_ext got %0d want 0", external_psum); end
        psum_initial_flag = 1'b0; accum_out = 36'h0_0001_ABCD;
        #1;
        checks++; if (internal_psum !== 16'hABCD) begin errors++; $display("FAIL mux_mac_int got %0h want abcd", internal_psum); end
        checks++; if (external_psum !== 16'd0) begin errors++; $display("FAIL mux_mac_ext got %0h want 0", external_psum); end
        accumulate_mode = 2'b00;
        #1;
        checks++; if ({internal_psum, external_psum} !== 32'd0) begin errors++; $display("FAIL mux_idle00 got %0h want 0", {internal_psum, external_psum}); end
        accumulate_mode = 2'b11;
        #1;
        checks++; if ({internal_psum, external_psum} !== 32'd0) begin errors++; $display("FAIL mux_idle11 got %0h want 0", {internal_psum, external_psum}); end
        accumulate_mode = 2'b00;
    endtask

    task automatic test_drain();
        logic        rdy [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        logic [15:0] exp [5] = '{16'd1, 16'd2, 16'd2, 16'd3, 16'd4};
        do_reset();
        for (int i = 0; i < 4; i++) write_pad(4'(i), 36'(i + 1));
        accumulate_mode = 2'b00;
        drain_start = 1'b1; drain_num = 5'd4;
        tick();
        drain_start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            psum_out_ready = rdy[i];
            if (i == 2) begin drain_start = 1'b1; drain_num = 5'd1; end
            @(negedge clk);
            checks++; if (psum_out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid_%0d got %0h want 1", i, psum_out_valid); end
            checks++; if (psum_out !== exp[i]) begin errors++; $display("FAIL drain_data_%0d got %0d want %0d", i, psum_out, exp[i]); end
            tick();
            drain_start = 1'b0;
        end
        psum_out_ready = 1'b0;
        @(negedge clk);
        checks++; if ({drain_done, drain_busy, psum_out_valid} !== 3'b110) begin errors++; $display("FAIL drain_done_pulse got %b want 110", {drain_done, drain_busy, psum_out_valid}); end
        tick();
        @(negedge clk);
        checks++; if ({drain_done, drain_busy} !== 2'b00) begin errors++; $display("FAIL drain_back_idle got %b want 00", {drain_done, drain_busy}); end
    endtask

    task automatic test_zero_drain();
        drain_start = 1'b1; drain_num = 5'd0;
        tick();
        drain_start = 1'b0;
        @(negedge clk);
        checks++; if ({drain_done, psum_out_valid} !== 2'b10) begin errors++; $display("FAIL zero_drain_done got %b want 10", {drain_done, psum_out_valid}); end
        tick();
        @(negedge clk);
        checks++; if ({drain_done, drain_busy} !== 2'b00) begin errors++; $display("FAIL zero_drain_idle got %b want 00", {drain_done, drain_busy}); end
    endtask

    task automatic test_write_stall();
        logic [15:0] d;
        mode = 1'b1; cnt_b = 4'd9; cnt_shift = '0; para_filter_num = '0;
        tick();
        drain_start = 1'b1; drain_num = 5'd2; psum_out_ready = 1'b1;
        tick();
        drain_start = 1'b0; mac_finish_flag = 1'b1; accum_out = 36'sd99;
        @(negedge clk);
        checks++; if (psum_out_valid !== 1'b0) begin errors++; $display("FAIL stall_valid got %0h want 0", psum_out_valid); end
        tick();
        mac_finish_flag = 1'b0;
        @(negedge clk);
        checks++; if ({psum_out_valid, psum_out} !== {1'b1, 16'd1}) begin errors++; $display("FAIL stall_beat0 got %0h want 10001", {psum_out_valid, psum_out}); end
        tick();
        @(negedge clk);
        checks++; if ({psum_out_valid, psum_out} !== {1'b1, 16'd2}) begin errors++; $display("FAIL stall_beat1 got %0h want 10002", {psum_out_valid, psum_out}); end
        tick();
        @(negedge clk);
        checks++; if (drain_done !== 1'b1) begin errors++; $display("FAIL stall_done got %0h want 1", drain_done); end
        psum_out_ready = 1'b0;
        tick();
        read_pad(4'd9, d);
        checks++; if (d !== 16'd99) begin errors++; $display("FAIL stall_write got %0d want 99", d); end
    endtask

    task automatic test_reset_mid_drain();
        logic [15:0] d;
        int          done_seen;
        accumulate_mode = 2'b00; mac_finish_flag = 1'b0; psum_store_flag = 1'b0;
        drain_start = 1'b1; drain_num = 5'd4; psum_out_ready = 1'b0;
        tick();
        drain_start = 1'b0;
        @(negedge clk);
        checks++; if (psum_out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0h want 1", psum_out_valid); end
        tick();
        rst_n = 1'b0;
        #1;
        checks++; if ({psum_out_valid, drain_busy, drain_done} !== 3'b000) begin errors++; $display("FAIL rst_async_outputs got %b want 000", {psum_out_valid, drain_busy, drain_done}); end
        tick();
        rst_n = 1'b1;
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (drain_done === 1'b1) done_seen++;
        end
        checks++; if (done_seen !== 0) begin errors++; $display("FAIL rst_no_done got %0d pulses want 0", done_seen); end
        for (int i = 0; i < 4; i++) begin
            read_pad(4'(i), d);
            checks++; if (d !== 16'd0) begin errors++; $display("FAIL rst_pad_%0d got %0d want 0", i, d); end
        end
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL rst_addr_err got %0h want 0", addr_err); end
    endtask

    initial begin
        test_reset();
        test_mode0_store();
        test_mode1_addr();
        test_saturation();
        test_operand_mux();
        test_drain();
        test_zero_drain();
        test_write_stall();
        test_reset_mid_drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
